// File: rtl/bip_acc_if.sv
// Command and result bundle between an accumulator-machine controller and
// the bip_acc_datapath block.
interface bip_acc_if #(
    parameter int DATA_W = 16,
    parameter int OPND_W = 11
);
    logic [1:0]        sel_a;
    logic              sel_b;
    logic              wr_acc;
    logic [2:0]        op;
    logic [OPND_W-1:0] operand;
    logic [DATA_W-1:0] in_memory_data;
    logic [DATA_W-1:0] out_memory_data;
    logic              flag_z;
    logic              flag_n;
    logic              flag_c;
    logic              flag_v;
    logic              busy;
    logic              done;

    modport master (
        output sel_a, sel_b, wr_acc, op, operand, in_memory_data,
        input  out_memory_data, flag_z, flag_n, flag_c, flag_v, busy, done
    );

    modport slave (
        input  sel_a, sel_b, wr_acc, op, operand, in_memory_data,
        output out_memory_data, flag_z, flag_n, flag_c, flag_v, busy, done
    );
endinterface

// File: rtl/bip_acc_datapath.sv
// Accumulator datapath: ALU with Z/N/C/V flags and an iterative unsigned
// shift-add multiplier that stalls new commands while it runs.
module bip_acc_datapath #(
    parameter int DATA_W = 16,
    parameter int OPND_W = 11,
    parameter int MUL_EN = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    bip_acc_if.slave bus
);
    localparam int         CNT_W  = $clog2(DATA_W + 1);
    localparam int         MSB    = DATA_W - 1;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    if ((OPND_W < 2) || (OPND_W > DATA_W)) begin : g_bad_opnd_w
        $error("bip_acc_datapath: OPND_W must satisfy 2 <= OPND_W <= DATA_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [DATA_W-1:0]     acc_r, acc_nxt_s;
    logic                  z_r, n_r, c_r, v_r;
    logic                  z_nxt_s, n_nxt_s, c_nxt_s, v_nxt_s;
    logic                  busy_r, done_r;
    logic [DATA_W-1:0]     opnd_ext_s, b_s, ld_val_s, alu_res_s;
    logic [DATA_W:0]       sum_s, diff_s;
    logic                  alu_c_s, alu_v_s, accept_s, mul_start_s;
    logic [2*DATA_W-1:0]   mcand_r, prod_r, prod_step_s;
    logic [DATA_W-1:0]     mplier_r;
    logic [CNT_W-1:0]      cnt_r;

    assign opnd_ext_s  = DATA_W'($signed(bus.operand));
    assign b_s         = bus.sel_b ? opnd_ext_s : bus.in_memory_data;
    assign ld_val_s    = bus.sel_a[0] ? opnd_ext_s : bus.in_memory_data;
    assign sum_s       = {1'b0, acc_r} + {1'b0, b_s};
    // The extra top bit of the difference is the unsigned borrow.
    assign diff_s      = {1'b0, acc_r} - {1'b0, b_s};
    assign accept_s    = bus.wr_acc && !busy_r && (bus.sel_a != 2'd3);
    assign prod_step_s = prod_r + (mplier_r[0] ? mcand_r : {(2*DATA_W){1'b0}});

    // Single-cycle ALU result with carry and overflow
    always_comb begin
        alu_res_s = acc_r;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res_s = sum_s[MSB:0];
                alu_c_s   = sum_s[DATA_W];
                alu_v_s   = (acc_r[MSB] == b_s[MSB]) && (alu_res_s[MSB] != acc_r[MSB]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[MSB:0];
                alu_c_s   = diff_s[DATA_W];
                alu_v_s   = (acc_r[MSB] != b_s[MSB]) && (alu_res_s[MSB] != acc_r[MSB]);
            end
            OP_AND: alu_res_s = acc_r & b_s;
            OP_OR:  alu_res_s = acc_r | b_s;
            OP_XOR: alu_res_s = acc_r ^ b_s;
            OP_SHL: begin
                alu_res_s = {acc_r[MSB-1:0], 1'b0};
                alu_c_s   = acc_r[MSB];
            end
            OP_SRA: begin
                alu_res_s = {acc_r[MSB], acc_r[MSB:1]};
                alu_c_s   = acc_r[0];
            end
            default: begin
                alu_res_s = acc_r;
                alu_c_s   = c_r;
                alu_v_s   = v_r;
            end
        endcase
    end

    // Next-state and accumulator/flag update decode
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        z_nxt_s     = z_r;
        n_nxt_s     = n_r;
        c_nxt_s     = c_r;
        v_nxt_s     = v_r;
        mul_start_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                state_nxt_s = ST_IDLE;
                if (accept_s) begin
                    case (bus.sel_a)
                        2'd0, 2'd1: begin
                            acc_nxt_s = ld_val_s;
                            z_nxt_s   = (ld_val_s == {DATA_W{1'b0}});
                            n_nxt_s   = ld_val_s[MSB];
                        end
                        2'd2: begin
                            if (bus.op == OP_MUL) begin
                                if (MUL_EN != 0) begin
                                    mul_start_s = 1'b1;
                                    state_nxt_s = ST_MUL;
                                end else begin
                                    mul_start_s = 1'b0;
                                end
                            end else begin
                                acc_nxt_s = alu_res_s;
                                z_nxt_s   = (alu_res_s == {DATA_W{1'b0}});
                                n_nxt_s   = alu_res_s[MSB];
                                c_nxt_s   = alu_c_s;
                                v_nxt_s   = alu_v_s;
                            end
                        end
                        default: acc_nxt_s = acc_r;
                    endcase
                end else begin
                    mul_start_s = 1'b0;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_W'(DATA_W - 1)) begin
                    acc_nxt_s   = prod_step_s[MSB:0];
                    z_nxt_s     = (prod_step_s[MSB:0] == {DATA_W{1'b0}});
                    n_nxt_s     = prod_step_s[MSB];
                    c_nxt_s     = |prod_step_s[2*DATA_W-1:DATA_W];
                    v_nxt_s     = 1'b0;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Accumulator, flags and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {DATA_W{1'b0}};
            z_r    <= 1'b0;
            n_r    <= 1'b0;
            c_r    <= 1'b0;
            v_r    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            acc_r  <= acc_nxt_s;
            z_r    <= z_nxt_s;
            n_r    <= n_nxt_s;
            c_r    <= c_nxt_s;
            v_r    <= v_nxt_s;
            busy_r <= (state_nxt_s == ST_MUL);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Shift-add multiplier: operands latched at start so later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {(2*DATA_W){1'b0}};
            mplier_r <= {DATA_W{1'b0}};
            prod_r   <= {(2*DATA_W){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (mul_start_s) begin
            mcand_r  <= {{DATA_W{1'b0}}, acc_r};
            mplier_r <= b_s;
            prod_r   <= {(2*DATA_W){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == ST_MUL) begin
            mcand_r  <= {mcand_r[2*DATA_W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[MSB:1]};
            prod_r   <= prod_step_s;
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            prod_r   <= prod_r;
            cnt_r    <= cnt_r;
        end
    end

    assign bus.out_memory_data = acc_r;
    assign bus.flag_z          = z_r;
    assign bus.flag_n          = n_r;
    assign bus.flag_c          = c_r;
    assign bus.flag_v          = v_r;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
endmodule

// File: tb/tb_bip_acc_datapath.sv
// Directed scoreboard bench for bip_acc_datapath (DATA_W=16, OPND_W=11).
module tb_bip_acc_datapath;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    typedef struct {
        logic [15:0] acc;
        logic [3:0]  flg;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    bip_acc_if #(.DATA_W(16), .OPND_W(11)) bus ();

    bip_acc_datapath #(.DATA_W(16), .OPND_W(11), .MUL_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_total = n_total + 1;
        assert (obs === req) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    endtask

    task automatic drive(input logic wr, input logic [1:0] sa, input logic sb,
                         input logic [2:0] o, input logic [10:0] opd, input logic [15:0] mem);
        bus.wr_acc         = wr;
        bus.sel_a          = sa;
        bus.sel_b          = sb;
        bus.op             = o;
        bus.operand        = opd;
        bus.in_memory_data = mem;
    endtask

    task automatic push(input logic [15:0] ea, input logic [3:0] ef, input string tag);
        exp_t e;
        e.acc = ea;
        e.flg = ef;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, {16'd0, bus.out_memory_data}, {16'd0, e.acc});
            check({e.tag, "_flags"}, {28'd0, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v},
                  {28'd0, e.flg});
        end
    endtask

    // flags are {Z,N,C,V}
    task automatic step(input logic wr, input logic [1:0] sa, input logic sb, input logic [2:0] o,
                        input logic [10:0] opd, input logic [15:0] mem,
                        input logic [15:0] ea, input logic [3:0] ef, input string tag);
        @(negedge clk);
        drive(wr, sa, sb, o, opd, mem);
        push(ea, ef, tag);
        @(posedge clk);
        #1;
        bus.wr_acc = 1'b0;
        check_front();
    endtask

    initial begin
        int  n_busy;
        bit  got_done;
        bit  saw_done;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        drive(1'b0, 2'd3, 1'b0, 3'd0, 11'd0, 16'd0);
        #2;
        check("reset_acc", {16'd0, bus.out_memory_data}, 32'd0);
        check("reset_flags", {28'd0, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 2'd2, 1'b0, 3'd1, 11'd0,    16'h0001, 16'hFFFF, 4'b0110, "sub_borrow");
        step(1'b1, 2'd1, 1'b0, 3'd0, 11'h7FF,  16'h0000, 16'hFFFF, 4'b0110, "load_opnd_neg");
        step(1'b1, 2'd0, 1'b0, 3'd0, 11'd0,    16'h7FFF, 16'h7FFF, 4'b0010, "load_mem");
        step(1'b1, 2'd2, 1'b1, 3'd0, 11'd1,    16'h0000, 16'h8000, 4'b0101, "add_ovf");
        step(1'b1, 2'd2, 1'b0, 3'd1, 11'd0,    16'h8000, 16'h0000, 4'b1000, "sub_zero");
        step(1'b1, 2'd0, 1'b0, 3'd0, 11'd0,    16'h8001, 16'h8001, 4'b0100, "load_8001");
        step(1'b1, 2'd2, 1'b0, 3'd6, 11'd0,    16'h1234, 16'hC000, 4'b0110, "sra1");
        step(1'b1, 2'd2, 1'b0, 3'd5, 11'd0,    16'h1234, 16'h8000, 4'b0110, "shl1");
        step(1'b1, 2'd2, 1'b0, 3'd2, 11'd0,    16'hF0F0, 16'h8000, 4'b0100, "and");
        step(1'b1, 2'd2, 1'b1, 3'd3, 11'h00F,  16'h0000, 16'h800F, 4'b0100, "or_opnd");
        step(1'b1, 2'd2, 1'b0, 3'd4, 11'd0,    16'h800F, 16'h0000, 4'b1000, "xor_zero");
        step(1'b0, 2'd1, 1'b0, 3'd0, 11'h7FF,  16'h0000, 16'h0000, 4'b1000, "no_wr_hold");
        step(1'b1, 2'd3, 1'b0, 3'd0, 11'h7FF,  16'h5555, 16'h0000, 4'b1000, "sel3_hold");
        step(1'b1, 2'd1, 1'b0, 3'd7, 11'h400,  16'h0000, 16'hFC00, 4'b0100, "op7_load");
        step(1'b1, 2'd0, 1'b0, 3'd0, 11'd0,    16'd300,  16'd300,  4'b0000, "load_300");

        // 300 * 300 = 0x15F90
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b0, 3'd7, 11'd0, 16'd300);
        push(16'h5F90, 4'b0010, "mul_result");
        @(posedge clk);
        #1;
        bus.wr_acc = 1'b0;
        n_busy   = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!got_done) begin
                if (bus.done) begin
                    got_done = 1'b1;
                end else begin
                    if (bus.busy) begin
                        n_busy = n_busy + 1;
                        check("mul_acc_hold", {16'd0, bus.out_memory_data}, 32'd300);
                    end
                    @(negedge clk);
                    drive(1'b1, 2'd0, 1'b0, 3'd0, 11'($urandom), 16'($urandom));
                    @(posedge clk);
                    #1;
                    bus.wr_acc = 1'b0;
                end
            end
        end
        check("mul_done_seen", {31'd0, got_done}, 32'd1);
        check("mul_busy_cycles", n_busy, 32'd16);
        check_front();
        step(1'b1, 2'd1, 1'b0, 3'd0, 11'd5, 16'h0000, 16'h0005, 4'b0010, "done_cycle_load");
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);

        // Reset in the middle of a multiply
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b1, 3'd7, 11'd3, 16'h0000);
        @(posedge clk);
        #1;
        bus.wr_acc = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc", {16'd0, bus.out_memory_data}, 32'd0);
        check("mid_rst_flags", {28'd0, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        drive(1'b1, 2'd1, 1'b0, 3'd0, 11'd3, 16'h0000);
        rst_n = 1'b1;
        push(16'h0003, 4'b0000, "first_after_reset");
        @(posedge clk);
        #1;
        bus.wr_acc = 1'b0;
        check_front();
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("no_done_after_reset", {31'd0, saw_done}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
